// File: rtl/ysyx_22050518_shift_stage_pkg.sv
// ysyx_22050518_shift_stage_pkg: core-wide XLEN and shift op encodings shared with the decoder
package ysyx_22050518_shift_stage_pkg;
  localparam int XLEN = 64;
  typedef enum logic [2:0] {
    OP_SLL  = 3'd0,
    OP_SRL  = 3'd1,
    OP_SRA  = 3'd2,
    OP_RSV3 = 3'd3,
    OP_SLLW = 3'd4,
    OP_SRLW = 3'd5,
    OP_SRAW = 3'd6,
    OP_RSV7 = 3'd7
  } shift_op_e;
  function automatic logic op_reserved(input logic [2:0] op);
    return &op[1:0];
  endfunction
endpackage

// File: rtl/ysyx_22050518_shift_core.sv
// ysyx_22050518_shift_core: combinational 64-bit and W-form shifter
module ysyx_22050518_shift_core
  import ysyx_22050518_shift_stage_pkg::*;
(
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src0,
  input  logic [XLEN-1:0] src1,
  output logic [XLEN-1:0] result,
  output logic            illegal
);
  logic [XLEN-1:0] sll, srl, sra, r64;
  logic [31:0]     sllw, srlw, sraw, r32;
  // arithmetic shifts are kept as standalone assignments so signedness never leaks through a mux
  always_comb begin
    sll     = src0 << src1[5:0];
    srl     = src0 >> src1[5:0];
    sra     = $signed(src0) >>> src1[5:0];
    sllw    = src0[31:0] << src1[4:0];
    srlw    = src0[31:0] >> src1[4:0];
    sraw    = $signed(src0[31:0]) >>> src1[4:0];
    r64     = op[1] ? sra : op[0] ? srl : sll;
    r32     = op[1] ? sraw : op[0] ? srlw : sllw;
    illegal = op_reserved(op);
    result  = illegal ? '0 : op[2] ? {{32{r32[31]}}, r32} : r64;
  end
endmodule

// File: rtl/ysyx_22050518_shift_stage.sv
// ysyx_22050518_shift_stage: two-stage valid/ready shift pipeline with flush
module ysyx_22050518_shift_stage
  import ysyx_22050518_shift_stage_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [XLEN-1:0]  in_src0,
  input  logic [XLEN-1:0]  in_src1,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);
  logic             s1_valid, s2_valid, s2_free, accept, advance;
  logic [2:0]       s1_op;
  logic [XLEN-1:0]  s1_src0, s1_src1, core_result;
  logic [TAG_W-1:0] s1_tag;
  logic             core_illegal;
  // handshake: S2 frees when empty or drained, S1 frees when empty or moving on
  always_comb begin
    s2_free   = !s2_valid || out_ready;
    in_ready  = !flush && (!s1_valid || s2_free);
    accept    = in_valid && in_ready;
    advance   = s1_valid && s2_free && !flush;
    out_valid = s2_valid;
  end
  ysyx_22050518_shift_core u_core (
    .op      (s1_op),
    .src0    (s1_src0),
    .src1    (s1_src1),
    .result  (core_result),
    .illegal (core_illegal)
  );
  // valid bits and S2 outputs; flush wins over any capture or advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      out_result  <= '0;
      out_tag     <= '0;
      out_illegal <= 1'b0;
    end else begin
      s1_valid <= flush ? 1'b0 : accept ? 1'b1 : advance ? 1'b0 : s1_valid;
      s2_valid <= flush ? 1'b0 : s2_free ? s1_valid : s2_valid;
      if (advance) begin
        out_result  <= core_result;
        out_tag     <= s1_tag;
        out_illegal <= core_illegal;
      end
    end
  end
  // S1 operand capture needs no reset since s1_valid qualifies it
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_op   <= in_op;
      s1_src0 <= in_src0;
      s1_src1 <= in_src1;
      s1_tag  <= in_tag;
    end
  end
endmodule

// File: tb/tb_ysyx_22050518_shift_stage.sv
// tb_ysyx_22050518_shift_stage: directed vectors checked against a queue-based reference model
module tb_ysyx_22050518_shift_stage;
  localparam int TW = 5;
  logic          clk = 1'b0, rst, in_valid, in_ready, flush, out_valid, out_ready, out_illegal;
  logic [2:0]    in_op;
  logic [63:0]   in_src0, in_src1, out_result;
  logic [TW-1:0] in_tag, out_tag;
  int            checks = 0, fails = 0;
  logic [63+TW+1:0] q[$];

  ysyx_22050518_shift_stage #(.TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src0(in_src0), .in_src1(in_src1), .in_tag(in_tag), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mdl(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [31:0] x, r;
    int s;
    if (op[1:0] == 2'd3) return 64'd0;
    if (!op[2]) begin
      s = int'(b[5:0]);
      case (op[1:0])
        2'd0: return a << s;
        2'd1: return a >> s;
        default: return (a >> s) | (a[63] ? ~(64'hFFFF_FFFF_FFFF_FFFF >> s) : 64'd0);
      endcase
    end
    s = int'(b[4:0]);
    x = a[31:0];
    case (op[1:0])
      2'd0: r = x << s;
      2'd1: r = x >> s;
      default: r = (x >> s) | (x[31] ? ~(32'hFFFF_FFFF >> s) : 32'd0);
    endcase
    return {{32{r[31]}}, r};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) q.delete();
    else begin
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL model_unexpected_out: got %h/%h/%b with nothing expected", out_result, out_tag, out_illegal);
        end else if ({out_result, out_tag, out_illegal} !== q[0]) begin
          fails++;
          $display("FAIL model_out: got %h/%h/%b expected %h/%h/%b", out_result, out_tag, out_illegal,
                   q[0][63+TW+1:TW+1], q[0][TW:1], q[0][0]);
        end
        if (out_ready && q.size() != 0) void'(q.pop_front());
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back({mdl(in_op, in_src0, in_src1), in_tag, in_op[1:0] == 2'd3});
    end
  end

  task automatic drive(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b, input logic [TW-1:0] t);
    in_valid = 1'b1; in_op = op; in_src0 = a; in_src1 = b; in_tag = t;
  endtask

  task automatic offer(output logic acc);
    @(negedge clk) acc = in_valid && in_ready;
    @(posedge clk) #1;
  endtask

  task automatic run1(input string name, input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                      input logic [TW-1:0] t, input logic [63:0] exp, input logic ill);
    int lat;
    drive(op, a, b, t);
    @(posedge clk) #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk) #1;
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'd2);
    chk({name, "_result"}, out_result, exp);
    chk({name, "_tag"}, 64'(out_tag), 64'(t));
    chk({name, "_illegal"}, 64'(out_illegal), 64'(ill));
    @(posedge clk) #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while ((q.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk) #1;
      n++;
    end
    chk({name, "_drained"}, 64'(q.size() + int'(out_valid)), 64'd0);
  endtask

  initial begin
    logic acc;
    int k, n;
    logic [63:0] held;
    rst = 1'b1; in_valid = 1'b0; in_op = 3'd0; in_src0 = '0; in_src1 = '0; in_tag = '0;
    flush = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_result", out_result, 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_out_illegal", 64'(out_illegal), 64'd0);
    rst = 1'b0;
    @(posedge clk) #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    run1("sra63", 3'd2, 64'h8000_0000_0000_0000, 64'd63, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    run1("sllw31", 3'd4, 64'd1, 64'hFFFF_FFFF_FFFF_FFDF, 5'd2, 64'hFFFF_FFFF_8000_0000, 1'b0);
    run1("srlw31", 3'd5, 64'hFFFF_FFFF_8000_0000, 64'd31, 5'd3, 64'h0000_0000_0000_0001, 1'b0);
    run1("sraw31", 3'd6, 64'hFFFF_FFFF_8000_0000, 64'd31, 5'd4, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    run1("rsv3", 3'd3, 64'hDEAD_BEEF_0000_1234, 64'd4, 5'd7, 64'd0, 1'b1);
    run1("sll_hi", 3'd0, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFC4, 5'd9, 64'h1234_5678_9ABC_DEF0, 1'b0);
    run1("srl_4", 3'd1, 64'hF000_0000_0000_0000, 64'd4, 5'd10, 64'h0F00_0000_0000_0000, 1'b0);

    out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 4; c++) begin
      drive(3'd0, 64'h1234, 64'(k + 1), 5'(k + 11));
      offer(acc);
      if (acc) k++;
      if (c == 1) held = out_result;
    end
    chk("bp_accepts", 64'(k), 64'd2);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    chk("bp_hold_result", out_result, held);
    chk("bp_first_result", out_result, 64'h2468);
    out_ready = 1'b1;
    n = 0;
    while (k < 3 && n < 20) begin
      drive(3'd0, 64'h1234, 64'(k + 1), 5'(k + 11));
      offer(acc);
      if (acc) k++;
      n++;
    end
    chk("bp_all_accepted", 64'(k), 64'd3);
    drain("bp");

    k = 0; n = 0;
    while (k < 16 && n < 200) begin
      out_ready = (n % 3) != 1;
      drive(3'(k % 8), 64'h8765_4321_F0E1_D2C3 ^ 64'(k * 64'h0101_0101), 64'(k * 7 + 30), 5'(k));
      offer(acc);
      if (acc) k++;
      n++;
    end
    chk("stream_accepted", 64'(k), 64'd16);
    drain("stream");

    out_ready = 1'b0;
    drive(3'd1, 64'hFF, 64'd1, 5'd20); offer(acc);
    drive(3'd2, 64'hFF, 64'd2, 5'd21); offer(acc);
    chk("fl_full_out_valid", 64'(out_valid), 64'd1);
    flush = 1'b1;
    drive(3'd0, 64'h55, 64'd1, 5'd22);
    #1;
    chk("fl_in_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk) #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("fl_out_valid_next", 64'(out_valid), 64'd0);
    acc = 1'b0;
    repeat (3) begin
      @(posedge clk) #1;
      acc = acc | out_valid;
    end
    chk("fl_nothing_captured", 64'(acc), 64'd0);

    out_ready = 1'b0;
    drive(3'd4, 64'h3, 64'd1, 5'd23); offer(acc);
    drive(3'd5, 64'h3, 64'd1, 5'd24); offer(acc);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_out_result", out_result, 64'd0);
    in_valid = 1'b0;
    @(posedge clk) #1;
    rst = 1'b0; out_ready = 1'b1;
    @(posedge clk) #1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    acc = 1'b0;
    repeat (3) begin
      acc = acc | out_valid;
      @(posedge clk) #1;
    end
    chk("mid_rst_discarded", 64'(acc), 64'd0);

    run1("post_rst_srlw", 3'd5, 64'h0000_0000_F000_0000, 64'd28, 5'd31, 64'h0000_0000_0000_000F, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
